// File: rtl/uart_pkg.sv
// Shared UART timing package.
// Purpose: default widths for the baud generator, divisor constants for
//   common baud rates at 50 MHz with 16x oversampling, and the encoding of
//   the divisor-write status reported on cfg_err.
// Ports: none (package).
package uart_pkg;

  localparam int DIV_W_DEF      = 16;
  localparam int FRAC_W_DEF     = 4;
  localparam int OVERSAMPLE_DEF = 16;

  // 50 MHz / (16 * baud), integer part plus sixteenths.
  localparam int BAUD_9600_INT    = 325;
  localparam int BAUD_9600_FRAC   = 8;
  localparam int BAUD_115200_INT  = 27;
  localparam int BAUD_115200_FRAC = 2;

  // Smallest integer divisor that still gives a sample period of >= 2 clocks.
  localparam int DIV_MIN = 2;

  typedef enum logic [0:0] {
    CFG_OK          = 1'b0,
    CFG_ERR_DIV_LOW = 1'b1
  } cfg_code_e;

endpackage

// File: rtl/frac_phase_acc.sv
// Fractional phase accumulator for the baud generator.
// Purpose: holds the fractional phase (units of 1/2**FRAC_W clock). At each
//   period start the caller pulses advance; the accumulator adds frac and the
//   carry out of FRAC_W bits tells the caller to stretch that period by one
//   clock. clear returns the phase to zero.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   clear     force phase to zero (wins over advance)
//   advance   add frac to the phase this cycle
//   frac      fractional divisor
//   carry     combinational carry of acc + frac (valid every cycle)
//   acc       current phase
module frac_phase_acc #(
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry,
  output logic [FRAC_W-1:0] acc
);

  logic [FRAC_W:0] sum;

  assign sum   = {1'b0, acc} + {1'b0, frac};
  assign carry = sum[FRAC_W];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (advance) begin
      acc <= sum[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Programmable UART baud-rate generator.
// Purpose: divides clk by div_int + div_frac/2**FRAC_W to produce a one-cycle
//   sample_tick, and a bit_tick on every OVERSAMPLE-th sample_tick. Divisor
//   writes go to a shadow register and take effect only at a period boundary
//   (terminal cycle), on resync, or at once while disabled, so a period is
//   never cut short or stretched by a divisor change.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   en           1 = count; 0 = counters and phase held at zero
//   resync       pulse: restart sample and bit phase from zero
//   div_wr       pulse: request load of div_int_in / div_frac_in
//   div_int_in   requested integer divisor (must be >= 2)
//   div_frac_in  requested fractional divisor
//   sample_tick  one-cycle pulse per sample period
//   bit_tick     one-cycle pulse per OVERSAMPLE sample periods
//   div_active   integer divisor currently in use
//   cfg_err      one-cycle pulse: last div_wr rejected
// Control inputs are single-cycle pulses with no back-pressure: div_wr and
// resync are acted on in the cycle they are sampled high and are never held
// off; a rejected write is reported by cfg_err in the following cycle.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int DIV_W        = DIV_W_DEF,
  parameter int FRAC_W       = FRAC_W_DEF,
  parameter int OVERSAMPLE   = OVERSAMPLE_DEF,
  parameter int DEF_DIV_INT  = BAUD_9600_INT,
  parameter int DEF_DIV_FRAC = BAUD_9600_FRAC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              resync,
  input  logic              div_wr,
  input  logic [DIV_W-1:0]  div_int_in,
  input  logic [FRAC_W-1:0] div_frac_in,
  output logic              sample_tick,
  output logic              bit_tick,
  output logic [DIV_W-1:0]  div_active,
  output logic              cfg_err
);

  localparam int IDX_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);
  // One bit of headroom: a stretched period at the largest divisor is 2**DIV_W.
  localparam int CNT_W = DIV_W + 1;

  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  samp_idx;
  logic              long_q;
  logic [DIV_W-1:0]  act_int, shd_int;
  logic [FRAC_W-1:0] act_frac, shd_frac;
  logic              pending;
  logic              sample_q, bit_q, err_q;

  logic              clear, run, period_start, carry, cur_long, terminal;
  logic              wr_ok, wr_bad, apply;
  logic [CNT_W-1:0]  last_cnt;
  logic [FRAC_W-1:0] frac_acc;

  assign clear        = resync || !en;
  assign run          = !clear;
  assign period_start = run && (cnt == '0);

  // The stretch decision is made at period start (carry is live then) and
  // held in long_q for the rest of the period.
  assign cur_long = (cnt == '0) ? carry : long_q;
  assign last_cnt = {1'b0, act_int} + {{DIV_W{1'b0}}, cur_long} - CNT_W'(1);
  assign terminal = run && (cnt == last_cnt);

  assign wr_ok  = div_wr && (div_int_in >= DIV_W'(DIV_MIN));
  assign wr_bad = div_wr && !wr_ok;
  assign apply  = terminal || clear;

  frac_phase_acc #(
    .FRAC_W (FRAC_W)
  ) u_frac (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .advance (period_start),
    .frac    (act_frac),
    .carry   (carry),
    .acc     (frac_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      samp_idx <= '0;
      long_q   <= 1'b0;
      sample_q <= 1'b0;
      bit_q    <= 1'b0;
      err_q    <= 1'b0;
      act_int  <= DIV_W'(DEF_DIV_INT);
      act_frac <= FRAC_W'(DEF_DIV_FRAC);
      shd_int  <= DIV_W'(DEF_DIV_INT);
      shd_frac <= FRAC_W'(DEF_DIV_FRAC);
      pending  <= 1'b0;
    end else begin
      sample_q <= terminal;
      bit_q    <= terminal && (samp_idx == IDX_LAST);
      err_q    <= wr_bad;

      if (clear) begin
        cnt      <= '0;
        samp_idx <= '0;
        long_q   <= 1'b0;
      end else begin
        if (period_start) begin
          long_q <= carry;
        end
        if (terminal) begin
          cnt      <= '0;
          samp_idx <= (samp_idx == IDX_LAST) ? '0 : samp_idx + IDX_W'(1);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      // A write landing on an apply cycle bypasses the shadow so it governs
      // the very next period.
      if (wr_ok) begin
        shd_int  <= div_int_in;
        shd_frac <= div_frac_in;
      end
      if (apply) begin
        pending <= 1'b0;
        if (wr_ok) begin
          act_int  <= div_int_in;
          act_frac <= div_frac_in;
        end else if (pending) begin
          act_int  <= shd_int;
          act_frac <= shd_frac;
        end
      end else if (wr_ok) begin
        pending <= 1'b1;
      end
    end
  end

  assign sample_tick = sample_q;
  assign bit_tick    = bit_q;
  assign div_active  = act_int;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Testbench for baud_tick_gen. Expected tick times come from the closed-form
// rule: the k-th sample tick after phase zero lands at
//   base + (k+1)*div + floor((k+1)*frac / 2**FRAC_W)
// where base is the last cycle before counting starts.
module tb_baud_tick_gen;
  import uart_pkg::*;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OVS    = 16;

  logic              clk = 1'b0;
  logic              rst, en, resync, div_wr;
  logic [DIV_W-1:0]  div_int_in;
  logic [FRAC_W-1:0] div_frac_in;
  logic              sample_tick, bit_tick, cfg_err;
  logic [DIV_W-1:0]  div_active;

  int cyc = 0;
  int st_q[$];
  int bt_q[$];
  int err_q[$];
  int orphan_bits = 0;
  logic [31:0] exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int s0, b0, base;

  baud_tick_gen #(
    .DIV_W        (DIV_W),
    .FRAC_W       (FRAC_W),
    .OVERSAMPLE   (OVS),
    .DEF_DIV_INT  (325),
    .DEF_DIV_FRAC (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .resync      (resync),
    .div_wr      (div_wr),
    .div_int_in  (div_int_in),
    .div_frac_in (div_frac_in),
    .sample_tick (sample_tick),
    .bit_tick    (bit_tick),
    .div_active  (div_active),
    .cfg_err     (cfg_err)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got time-out expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (sample_tick) st_q.push_back(cyc);
    if (bit_tick) bt_q.push_back(cyc);
    if (bit_tick && !sample_tick) orphan_bits++;
    if (cfg_err) err_q.push_back(cyc);
  end

  // ---------------- checking ----------------
  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int exp_tick(int b, int div, int frac, int k);
    return b + (k + 1) * div + (((k + 1) * frac) >> FRAC_W);
  endfunction

  function automatic int st_at(int idx);
    return (idx < st_q.size()) ? st_q[idx] : -1;
  endfunction

  function automatic int bt_at(int idx);
    return (idx < bt_q.size()) ? bt_q[idx] : -1;
  endfunction

  // ---------------- drivers ----------------
  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(int t);
    while (cyc < t) step(1);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; resync = 1'b0; div_wr = 1'b0;
    div_int_in = '0; div_frac_in = '0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic write_div(int i, int f);
    div_int_in  = DIV_W'(i);
    div_frac_in = FRAC_W'(f);
    div_wr = 1'b1;
    step(1);
    div_wr = 1'b0;
  endtask

  // Disable, load divisor (applies at once while disabled), enable.
  task automatic start_run(int i, int f);
    en = 1'b0;
    step(1);
    write_div(i, f);
    s0 = st_q.size();
    b0 = bt_q.size();
    en = 1'b1;
    base = cyc;
  endtask

  task automatic wait_ticks(string tag, int n, int budget);
    int t0;
    t0 = cyc;
    while (st_q.size() < n && (cyc - t0) < budget) step(1);
    if (st_q.size() < n) chk({tag, "_timeout"}, st_q.size(), n);
  endtask

  task automatic check_seq(string tag, int first, int b, int div, int frac, int n);
    for (int k = 0; k < n; k++) exp_q.push_back(32'(exp_tick(b, div, frac, k)));
    for (int k = 0; k < n; k++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      chk(tag, st_at(first + k), int'(e));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d, f, r, rbase, e0;
    step(1);
    do_reset();
    step(1);
    chk("rst_sample_tick", int'(sample_tick), 0);
    chk("rst_bit_tick", int'(bit_tick), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_div_active", int'(div_active), 325);

    // 325/0, 16x: sample every 325, bit every 5200.
    start_run(325, 0);
    wait_ticks("t1", s0 + 32, 11000);
    check_seq("t1_sample", s0, base, 325, 0, 32);
    chk("t1_bit0", bt_at(b0), base + 5200);
    chk("t1_bit1", bt_at(b0 + 1), base + 10400);
    chk("t1_bit_count", bt_q.size() - b0, 2);

    // 10/8: alternating 10 and 11 clock periods, 16 periods = 168 clocks.
    start_run(10, 8);
    wait_ticks("t2", s0 + 32, 400);
    check_seq("t2_sample", s0, base, 10, 8, 32);
    chk("t2_16_periods", st_at(s0 + 15) - base, 168);

    // 115200 preset and random divisors.
    start_run(BAUD_115200_INT, BAUD_115200_FRAC);
    wait_ticks("t115k", s0 + 20, 700);
    check_seq("t115k_sample", s0, base, 27, 2, 20);
    for (int n = 0; n < 6; n++) begin
      d = $urandom_range(2, 40);
      f = $urandom_range(0, 15);
      start_run(d, f);
      wait_ticks("trand", s0 + 20, 900);
      check_seq("trand_sample", s0, base, d, f, 20);
    end

    // Mid-period write 20/0 into 10/0: current period stays 10.
    start_run(10, 0);
    r = $urandom_range(1, 7);
    wait_cyc(base + r);
    write_div(20, 0);
    chk("t3_active_before", int'(div_active), 10);
    wait_cyc(base + 10);
    chk("t3_active_at_term", int'(div_active), 20);
    // Write coinciding with the terminal at base+50 governs the next period.
    wait_cyc(base + 49);
    write_div(15, 0);
    wait_ticks("t3", s0 + 5, 200);
    chk("t3_tick0", st_at(s0), base + 10);
    chk("t3_tick1", st_at(s0 + 1), base + 30);
    chk("t3_tick2", st_at(s0 + 2), base + 50);
    chk("t3_tick3", st_at(s0 + 3), base + 65);
    chk("t3_tick4", st_at(s0 + 4), base + 80);

    // resync at cnt=7, samp_idx=5.
    start_run(10, 0);
    wait_cyc(base + 57);
    resync = 1'b1;
    step(1);
    resync = 1'b0;
    rbase = base + 58;
    wait_ticks("t4", s0 + 21, 400);
    check_seq("t4_pre", s0, base, 10, 0, 5);
    check_seq("t4_post", s0 + 5, rbase, 10, 0, 16);
    chk("t4_bit", bt_at(b0), rbase + 160);

    // Illegal divisor: cfg_err pulse, divisor and ticks unchanged.
    start_run(10, 0);
    e0 = err_q.size();
    wait_cyc(base + 13);
    write_div(1, 0);
    step(3);
    chk("t5_err_count", err_q.size() - e0, 1);
    chk("t5_err_time", (err_q.size() > e0) ? err_q[e0] : -1, base + 14);
    chk("t5_active", int'(div_active), 10);
    wait_ticks("t5", s0 + 6, 200);
    check_seq("t5_sample", s0, base, 10, 0, 6);

    // en low for 50 clocks mid-run.
    start_run(10, 0);
    wait_cyc(base + 23);
    en = 1'b0;
    wait_cyc(base + 73);
    chk("t6_ticks_while_low", st_q.size() - s0, 2);
    en = 1'b1;
    rbase = cyc;
    wait_ticks("t6", s0 + 3, 200);
    chk("t6_first_after", st_at(s0 + 2), rbase + 10);

    // Reset discards a pending write; defaults 325/8 return.
    start_run(10, 0);
    wait_cyc(base + 3);
    write_div(30, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t7_active_after_rst", int'(div_active), 325);
    s0 = st_q.size();
    en = 1'b1;
    base = cyc;
    wait_ticks("t7", s0 + 2, 800);
    check_seq("t7_default", s0, base, 325, 8, 2);

    chk("bit_without_sample", orphan_bits, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
